// File: rtl/cbus_arbiter.sv
// Two-master (instruction/data) to single cbus arbiter with latched requests.
// Define ARB_DATA_PRIORITY_EN for fixed data priority; otherwise ties are round-robin.

package cbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        logic [63:0]     addr;
        logic [7:0]      strobe;
        logic [63:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic              owner_q;
    logic              rr_prev_q;
    cbus_req_t         req_q;
    logic [DATA_W-1:0] data_q;

    logic      grant;
    cbus_req_t req_d;

    // Round-robin memory starts at "data" so the first tie after reset goes to instruction.
    always_comb begin
`ifdef ARB_DATA_PRIORITY_EN
        grant = dreq.valid;
`else
        if (ireq.valid && dreq.valid) begin
            grant = ~rr_prev_q;
        end else begin
            grant = dreq.valid;
        end
`endif
    end

    always_comb begin
        req_d       = '0;
        req_d.valid = 1'b1;
        req_d.len   = MLEN1;
        req_d.burst = AXI_BURST_FIXED;
        if (grant) begin
            req_d.is_write = |dreq.strobe;
            req_d.size     = dreq.size;
            req_d.addr     = dreq.addr;
            req_d.strobe   = dreq.strobe;
            req_d.data     = dreq.data;
        end else begin
            req_d.is_write = 1'b0;
            req_d.size     = MSIZE4;
            req_d.addr     = ireq.addr;
            req_d.strobe   = 8'h00;
            req_d.data     = 64'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            rr_prev_q <= 1'b1;
            req_q     <= '0;
            data_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ireq.valid || dreq.valid) begin
                        owner_q   <= grant;
                        rr_prev_q <= grant;
                        req_q     <= req_d;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    // Non-final beats are ignored; only ready+last completes.
                    if (oresp.ready && oresp.last) begin
                        data_q  <= oresp.data;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign oreq = (state_q == StBusy) ? req_q : '0;

    always_comb begin
        iresp = '0;
        dresp = '0;
        if (state_q == StDone) begin
            if (owner_q) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = data_q;
            end else begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = data_q;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter; expectations track ARB_DATA_PRIORITY_EN.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int n_checks = 0;
    int n_fail   = 0;

    cbus_arbiter #(
        .DATA_W(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ireq (ireq),
        .iresp(iresp),
        .dreq (dreq),
        .dresp(dresp),
        .oreq (oreq),
        .oresp(oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [2:0]  exp_owner;
    logic        exp_after_rst;
    logic [63:0] iaddr;
    logic [63:0] daddr;

    initial begin
`ifdef ARB_DATA_PRIORITY_EN
        exp_owner     = 3'b111;
        exp_after_rst = 1'b1;
`else
        exp_owner     = 3'b010;
        exp_after_rst = 1'b0;
`endif
        iaddr = 64'h0000_0000_0000_1000;
        daddr = 64'h0000_0000_0000_2000;

        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        tick();
        tick();
        chk("rst_oreq_valid", 64'(oreq.valid), 64'd0);
        chk("rst_oreq_addr", oreq.addr, 64'd0);
        chk("rst_iresp", 64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
        chk("rst_dresp", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_oreq_valid", 64'(oreq.valid), 64'd0);

        // Data load
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_0010;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        tick();
        chk("ld_valid", 64'(oreq.valid), 64'd1);
        chk("ld_is_write", 64'(oreq.is_write), 64'd0);
        chk("ld_addr", oreq.addr, 64'h0000_0000_8000_0010);
        chk("ld_size", 64'(oreq.size), 64'(MSIZE8));
        chk("ld_len", 64'(oreq.len), 64'(MLEN1));
        chk("ld_burst", 64'(oreq.burst), 64'(AXI_BURST_FIXED));
        chk("ld_busy_dresp", 64'(dresp.data_ok), 64'd0);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h1122_3344_5566_7788;
        tick();
        chk("ld_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("ld_addr_ok", 64'(dresp.addr_ok), 64'd1);
        chk("ld_data", dresp.data, 64'h1122_3344_5566_7788);
        chk("ld_iresp_zero", {62'd0, iresp.addr_ok, iresp.data_ok} | iresp.data, 64'd0);
        chk("ld_done_oreq", 64'(oreq.valid), 64'd0);
        dreq.valid = 1'b0;
        oresp      = '0;
        tick();
        chk("ld_after_dresp", 64'(dresp.data_ok), 64'd0);
        chk("ld_after_oreq_addr", oreq.addr, 64'd0);
        tick();
        chk("ld_no_regrant", 64'(oreq.valid), 64'd0);

        // Data store
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_0020;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0f;
        dreq.data   = 64'h0000_0000_DEAD_BEEF;
        tick();
        chk("st_is_write", 64'(oreq.is_write), 64'd1);
        chk("st_strobe", 64'(oreq.strobe), 64'h0f);
        chk("st_data", oreq.data, 64'h0000_0000_DEAD_BEEF);
        chk("st_size", 64'(oreq.size), 64'(MSIZE4));
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h0;
        tick();
        chk("st_data_ok", 64'(dresp.data_ok), 64'd1);
        dreq.valid = 1'b0;
        oresp      = '0;
        tick();
        chk("st_data_ok_once", 64'(dresp.data_ok), 64'd0);

        // Multi-beat with address change during BUSY
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_0100;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        tick();
        dreq.addr   = 64'h0000_0000_8000_0200;
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        oresp.data  = 64'hAAAA_AAAA_AAAA_AAAA;
        chk("mb_addr0", oreq.addr, 64'h0000_0000_8000_0100);
        tick();
        chk("mb_busy1", 64'(oreq.valid), 64'd1);
        chk("mb_addr1", oreq.addr, 64'h0000_0000_8000_0100);
        chk("mb_no_ok1", 64'(dresp.data_ok), 64'd0);
        tick();
        chk("mb_busy2", 64'(oreq.valid), 64'd1);
        chk("mb_no_ok2", 64'(dresp.data_ok), 64'd0);
        oresp.last = 1'b1;
        oresp.data = 64'h0102_0304_0506_0708;
        tick();
        chk("mb_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("mb_data", dresp.data, 64'h0102_0304_0506_0708);
        dreq.valid = 1'b0;
        oresp      = '0;
        tick();
        chk("mb_data_ok_once", 64'(dresp.data_ok), 64'd0);

        // Three contended transactions; previous owner was data
        ireq.valid  = 1'b1;
        ireq.addr   = iaddr;
        dreq.valid  = 1'b1;
        dreq.addr   = daddr;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rr%0d_addr", k), oreq.addr, exp_owner[k] ? daddr : iaddr);
            chk($sformatf("rr%0d_size", k), 64'(oreq.size),
                exp_owner[k] ? 64'(MSIZE8) : 64'(MSIZE4));
            oresp.ready = 1'b1;
            oresp.last  = 1'b1;
            oresp.data  = 64'h100 + 64'(k);
            tick();
            chk($sformatf("rr%0d_i_ok", k), 64'(iresp.data_ok), 64'(!exp_owner[k]));
            chk($sformatf("rr%0d_d_ok", k), 64'(dresp.data_ok), 64'(exp_owner[k]));
            chk($sformatf("rr%0d_data", k), exp_owner[k] ? dresp.data : iresp.data,
                64'h100 + 64'(k));
            oresp = '0;
            tick();
        end
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        tick();

        // Reset during BUSY aborts the transfer
        dreq.valid = 1'b1;
        dreq.addr  = 64'h0000_0000_8000_0040;
        tick();
        chk("ab_busy", 64'(oreq.valid), 64'd1);
        reset       = 1'b1;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h0BAD;
        tick();
        chk("ab_oreq_valid", 64'(oreq.valid), 64'd0);
        chk("ab_no_ok0", 64'(dresp.data_ok), 64'd0);
        reset      = 1'b0;
        oresp      = '0;
        dreq.valid = 1'b0;
        tick();
        chk("ab_no_ok1", 64'(dresp.data_ok), 64'd0);
        tick();
        chk("ab_no_ok2", 64'(dresp.data_ok), 64'd0);
        chk("ab_idle", 64'(oreq.valid), 64'd0);

        // First tie after reset
        ireq.valid = 1'b1;
        dreq.valid = 1'b1;
        dreq.addr  = daddr;
        tick();
        chk("pr_addr", oreq.addr, exp_after_rst ? daddr : iaddr);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h55;
        tick();
        chk("pr_i_ok", 64'(iresp.data_ok), 64'(!exp_after_rst));
        chk("pr_d_ok", 64'(dresp.data_ok), 64'(exp_after_rst));
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        oresp      = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the data-bus width in bits; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ireq, input, ibus_req_t, the instruction-fetch request (valid, addr).
REQ-005 SHALL have port iresp, output, ibus_resp_t, the instruction response (addr_ok, data_ok, data).
REQ-006 SHALL have port dreq, input, dbus_req_t, the data-memory request (valid, addr, size, strobe, data).
REQ-007 SHALL have port dresp, output, dbus_resp_t, the data-memory response (addr_ok, data_ok, data).
REQ-008 SHALL have port oreq, output, cbus_req_t, the single request to the memory side.
REQ-009 SHALL have port oresp, input, cbus_resp_t, the memory-side response (ready, last, data).

Function
REQ-010 SHALL implement states IDLE, BUSY and DONE, plus a 1-bit owner register (0 = instruction, 1 = data).
REQ-011 In IDLE with no valid request: stay in IDLE, oreq.valid=0.
REQ-012 In IDLE with at least one valid request: pick the owner by the policy in REQ-025/026, latch that request into an internal register, go to BUSY.
REQ-013 In BUSY: drive oreq from the latched register with valid=1, len=MLEN1, burst=AXI_BURST_FIXED.
REQ-014 Request field mapping: is_write = |strobe; a data request passes size, addr, strobe and data unchanged; an instruction request uses size=MSIZE4, strobe=0, data=0.
REQ-015 In BUSY, when oresp.ready=1 and oresp.last=1: capture oresp.data, go to DONE.
REQ-016 In BUSY, oresp.ready=1 with last=0 SHALL be ignored; the block stays in BUSY.
REQ-017 In DONE, for exactly one cycle: the owner's addr_ok=1, data_ok=1 and data = captured data; the other master sees all zeros. Then go to IDLE.
REQ-018 Minimum latency: request sampled in IDLE at cycle N, oreq.valid=1 at N+1, ready+last at N+1, data_ok at N+2.
REQ-019 Masters that drop valid on the edge ending DONE SHALL NOT be re-granted.
REQ-020 A change to the owner's request inputs during BUSY SHALL NOT alter oreq (latched semantics).
REQ-021 The non-owner's valid request SHALL be held pending without response and considered in the next IDLE.
REQ-022 The oreq fields SHALL be 0 whenever oreq.valid=0; iresp and dresp SHALL be 0 outside DONE.

Reset
REQ-023 While reset=1 on a clock edge: state=IDLE, owner=0, latched request=0, captured data=0.
REQ-024 Asserting reset mid-transaction SHALL abort it: oreq.valid=0 and no data_ok on the cycle after the reset edge.

Configuration
REQ-025 Macro ARB_DATA_PRIORITY_EN defined: fixed priority; when both requests are valid in IDLE, data wins every time.
REQ-026 Macro undefined: round-robin; on a tie, grant the master that did not own the previous transaction (instruction first after reset).

Verification
REQ-027 Data load only: dreq addr=0x8000_0010, size=MSIZE8, strobe=0; memory returns ready+last with 0x1122334455667788 on the first BUSY cycle -> oreq is_write=0, dresp.data_ok one cycle later with that data, iresp all zero.
REQ-028 Data store: strobe=8'h0f, data=0xDEADBEEF -> oreq.is_write=1, strobe=8'h0f, data=0xDEADBEEF; dresp.data_ok=1 for exactly one cycle.
REQ-029 Simultaneous ireq and dreq for 3 back-to-back transactions -> with macro: grants D, D, D; without macro: I, D, I.
REQ-030 Memory asserts ready with last=0 for 2 cycles, then ready+last -> the block stays in BUSY throughout and data_ok arrives exactly once after last.
REQ-031 Reset asserted during BUSY -> the next cycle shows IDLE, oreq.valid=0, and neither data_ok is ever emitted for the aborted request.
REQ-032 Owner changes dreq.addr during BUSY -> oreq.addr keeps the originally latched address.
